hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard controller that drives the stall/flush inputs of the fetch-to-decode and decode-to-execute pipeline registers. It detects load-use hazards, branch-taken redirects, data-memory wait states and HI/LO hazards against an iterative divider. A small divider-tracking FSM and saturating performance counters give it sequential behaviour. It sits beside the decode stage and consumes decode and execute stage fields.

Parameters:
REG_ADDR_WIDTH, 5, register-file address width
DIV_CYCLES, 32, divider latency in cycles from div_start to result valid (>=2)
CNT_WIDTH, 32, width of the performance counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
dec_valid  in  1  decode stage holds a valid instruction
dec_rs_addr  in  REG_ADDR_WIDTH  decode rs index
dec_rt_addr  in  REG_ADDR_WIDTH  decode rt index
dec_uses_rs  in  1  decode instruction reads rs
dec_uses_rt  in  1  decode instruction reads rt
dec_is_div  in  1  decode instruction is div/divu
dec_reads_hilo  in  1  decode instruction is mfhi/mflo/mthi/mtlo
exec_is_load  in  1  execute stage holds a load
exec_reg_write  in  1  execute stage writes a register
exec_rd_addr  in  REG_ADDR_WIDTH  execute stage destination index
branch_taken  in  1  branch/jump resolved taken in execute stage
mem_busy  in  1  data memory not ready this cycle
stall_pc  out  1  hold PC
stall_f2d  out  1  stall fetch-to-decode register
flush_f2d  out  1  flush fetch-to-decode register
stall_d2e  out  1  stall decode-to-execute register
flush_d2e  out  1  flush decode-to-execute register (bubble insert)
div_start  out  1  one-cycle pulse: launch divider
div_busy  out  1  divider in flight
stall_cycles  out  CNT_WIDTH  cycles with stall_pc=1, saturating
flush_events  out  CNT_WIDTH  cycles with flush_f2d=1, saturating

Behaviour:
- Stall/flush outputs are combinational from inputs and FSM state. Pipeline registers give stall priority over flush, so a bubble is stall_d2e=0 and flush_d2e=1.
- While rst_n=0, all stall/flush outputs, div_start and div_busy are 0, FSM is IDLE and counters are 0.
- Priority, highest first; only one rule applies per cycle:
  1. mem_busy=1: stall_pc=stall_f2d=stall_d2e=1, all flushes 0, div_start=0.
  2. branch_taken=1: flush_f2d=flush_d2e=1, all stalls 0, div_start=0. The decode instruction is squashed.
  3. Load-use: dec_valid & exec_is_load & exec_reg_write & exec_rd_addr!=0 & ((dec_uses_rs & rs==rd) | (dec_uses_rt & rt==rd)). Then stall_pc=stall_f2d=1, flush_d2e=1, stall_d2e=0.
  4. HI/LO hazard: dec_valid & div_busy & (dec_is_div | dec_reads_hilo). Same outputs as rule 3.
  5. Otherwise all stall/flush outputs are 0.
- div_start = dec_valid & dec_is_div & no rule 1-4 active. It fires when the div advances into execute.
- Divider FSM:
  - IDLE: on div_start, go to BUSY and load cnt=DIV_CYCLES-1.
  - BUSY: div_busy=1; cnt decrements every cycle, including during mem_busy and branch_taken. When cnt==0, go to IDLE next edge.
  - div_busy is registered. It is 1 for exactly DIV_CYCLES cycles, starting the cycle after div_start.
  - div_start cannot occur in BUSY, because rule 4 blocks it.
- Counters:
  - stall_cycles increments on every cycle with stall_pc=1.
  - flush_events increments on every cycle with flush_f2d=1.
  - Both saturate at all-ones and do not wrap.
- Register index 0 never causes a load-use hazard.
- Reset asserted mid-division returns the FSM to IDLE immediately and drops div_busy asynchronously.

Test Plan:
- Load r5 in exec, decode add r3,r5,r4 with uses_rs=1 -> one cycle of stall_pc=stall_f2d=1, flush_d2e=1, stall_d2e=0. Next cycle (exec_is_load=0) all outputs 0; stall_cycles=1.
- Load r0 in exec, decode reads r0 -> no stall; same load to r7 with decode reading rt=7 and uses_rt=0 -> no stall.
- Same cycle: load-use hazard, branch_taken=1 and mem_busy=1 -> stalls all 1, flushes 0. Drop mem_busy -> flush_f2d=flush_d2e=1, stalls 0, flush_events=1.
- DIV_CYCLES=4: decode div -> div_start pulse for 1 cycle; div_busy high for 4 cycles. A following mflo in decode stalls for those cycles, then issues. A second div issued during BUSY gets no div_start until IDLE.
- div in decode with branch_taken=1 -> div_start=0, FSM stays IDLE.
- rst_n pulsed low during BUSY -> div_busy=0 and counters=0 at once. After release, outputs are 0 with idle inputs.
- Force 2^CNT_WIDTH+3 stall cycles (CNT_WIDTH=4 in the test) -> stall_cycles holds 4'hF.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Decode/execute hazard fields into the hazard controller and the
// stall/flush/divider/counter signals it hands back to the pipeline.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
);
  logic                      dec_valid;
  logic [REG_ADDR_WIDTH-1:0] dec_rs_addr;
  logic [REG_ADDR_WIDTH-1:0] dec_rt_addr;
  logic                      dec_uses_rs;
  logic                      dec_uses_rt;
  logic                      dec_is_div;
  logic                      dec_reads_hilo;
  logic                      exec_is_load;
  logic                      exec_reg_write;
  logic [REG_ADDR_WIDTH-1:0] exec_rd_addr;
  logic                      branch_taken;
  logic                      mem_busy;

  logic                      stall_pc;
  logic                      stall_f2d;
  logic                      flush_f2d;
  logic                      stall_d2e;
  logic                      flush_d2e;
  logic                      div_start;
  logic                      div_busy;
  logic [CNT_WIDTH-1:0]      stall_cycles;
  logic [CNT_WIDTH-1:0]      flush_events;

  modport master (
    output dec_valid, dec_rs_addr, dec_rt_addr, dec_uses_rs, dec_uses_rt,
           dec_is_div, dec_reads_hilo, exec_is_load, exec_reg_write,
           exec_rd_addr, branch_taken, mem_busy,
    input  stall_pc, stall_f2d, flush_f2d, stall_d2e, flush_d2e,
           div_start, div_busy, stall_cycles, flush_events
  );

  modport slave (
    input  dec_valid, dec_rs_addr, dec_rt_addr, dec_uses_rs, dec_uses_rt,
           dec_is_div, dec_reads_hilo, exec_is_load, exec_reg_write,
           exec_rd_addr, branch_taken, mem_busy,
    output stall_pc, stall_f2d, flush_f2d, stall_d2e, flush_d2e,
           div_start, div_busy, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/flush generation, an
// iterative-divider tracking FSM and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DIV_CYCLES     = 32,
  parameter int CNT_WIDTH      = 32
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);
  localparam int DCW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic {IDLE, BUSY} div_state_t;

  div_state_t           state, state_nxt;
  logic [DCW-1:0]       cnt, cnt_nxt;
  logic                 div_busy;
  logic                 rs_hit, rt_hit, load_use, hilo_haz;
  logic                 stall_pc, stall_f2d, flush_f2d, stall_d2e, flush_d2e;
  logic                 div_start;
  logic [CNT_WIDTH-1:0] stall_cycles, flush_events;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  assign div_busy = (state == BUSY);
  assign rs_hit   = hz.dec_uses_rs && (hz.dec_rs_addr == hz.exec_rd_addr);
  assign rt_hit   = hz.dec_uses_rt && (hz.dec_rt_addr == hz.exec_rd_addr);
  assign load_use = hz.dec_valid && hz.exec_is_load && hz.exec_reg_write &&
                    (hz.exec_rd_addr != '0) && (rs_hit || rt_hit);
  assign hilo_haz = hz.dec_valid && div_busy && (hz.dec_is_div || hz.dec_reads_hilo);

  // Outputs are forced low while reset is held, even with active inputs.
  always_comb begin
    stall_pc  = 1'b0;
    stall_f2d = 1'b0;
    flush_f2d = 1'b0;
    stall_d2e = 1'b0;
    flush_d2e = 1'b0;
    div_start = 1'b0;
    if (rst_n) begin
      if (hz.mem_busy) begin
        stall_pc  = 1'b1;
        stall_f2d = 1'b1;
        stall_d2e = 1'b1;
      end else if (hz.branch_taken) begin
        flush_f2d = 1'b1;
        flush_d2e = 1'b1;
      end else if (load_use || hilo_haz) begin
        stall_pc  = 1'b1;
        stall_f2d = 1'b1;
        flush_d2e = 1'b1;
      end else if (hz.dec_valid && hz.dec_is_div) begin
        div_start = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (div_start) begin
        state_nxt = BUSY;
        cnt_nxt   = DCW'(DIV_CYCLES - 1);
      end
      BUSY: if (cnt == '0) state_nxt = IDLE;
            else           cnt_nxt   = cnt - DCW'(1);
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      stall_cycles <= sat_inc(stall_cycles, stall_pc);
      flush_events <= sat_inc(flush_events, flush_f2d);
    end
  end

  assign hz.stall_pc     = stall_pc;
  assign hz.stall_f2d    = stall_f2d;
  assign hz.flush_f2d    = flush_f2d;
  assign hz.stall_d2e    = stall_d2e;
  assign hz.flush_d2e    = flush_d2e;
  assign hz.div_start    = div_start;
  assign hz.div_busy     = div_busy;
  assign hz.stall_cycles = stall_cycles;
  assign hz.flush_events = flush_events;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_hazard_ctrl;
  localparam int RAW = 5;
  localparam int DVC = 4;
  localparam int CW  = 4;

  // ctl = {stall_pc, stall_f2d, flush_f2d, stall_d2e, flush_d2e, div_start, div_busy}
  localparam logic [6:0] NONE = 7'b00000_00;
  localparam logic [6:0] LU   = 7'b11001_00;
  localparam logic [6:0] MEM  = 7'b11010_00;
  localparam logic [6:0] BR   = 7'b00101_00;
  localparam logic [6:0] DS   = 7'b00000_10;
  localparam logic [6:0] DB   = 7'b00000_01;

  typedef struct {
    string       name;
    logic [6:0]  ctl;
    logic [CW-1:0] sc;
    logic [CW-1:0] fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  hazard_ctrl_if #(.REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW)) bus ();

  hazard_ctrl #(.REG_ADDR_WIDTH(RAW), .DIV_CYCLES(DVC), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = exp_q.pop_front();
      act = {bus.stall_pc, bus.stall_f2d, bus.flush_f2d, bus.stall_d2e,
             bus.flush_d2e, bus.div_start, bus.div_busy};
      n_checks++;
      if (act !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
      end
      n_checks++;
      if (bus.stall_cycles !== e.sc) begin
        n_fail++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", e.name, bus.stall_cycles, e.sc);
      end
      n_checks++;
      if (bus.flush_events !== e.fe) begin
        n_fail++;
        $display("FAIL %s flush_events: got %0d expected %0d", e.name, bus.flush_events, e.fe);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_valid      = 1'b0;
    bus.dec_rs_addr    = '0;
    bus.dec_rt_addr    = '0;
    bus.dec_uses_rs    = 1'b0;
    bus.dec_uses_rt    = 1'b0;
    bus.dec_is_div     = 1'b0;
    bus.dec_reads_hilo = 1'b0;
    bus.exec_is_load   = 1'b0;
    bus.exec_reg_write = 1'b0;
    bus.exec_rd_addr   = '0;
    bus.branch_taken   = 1'b0;
    bus.mem_busy       = 1'b0;
  endtask

  task automatic dec(input logic [RAW-1:0] rs, input logic [RAW-1:0] rt,
                     input logic urs, input logic urt,
                     input logic isdiv, input logic hilo);
    bus.dec_valid      = 1'b1;
    bus.dec_rs_addr    = rs;
    bus.dec_rt_addr    = rt;
    bus.dec_uses_rs    = urs;
    bus.dec_uses_rt    = urt;
    bus.dec_is_div     = isdiv;
    bus.dec_reads_hilo = hilo;
  endtask

  task automatic exe(input logic ld, input logic rw, input logic [RAW-1:0] rd);
    bus.exec_is_load   = ld;
    bus.exec_reg_write = rw;
    bus.exec_rd_addr   = rd;
  endtask

  task automatic expect_out(input string name, input logic [6:0] ctl,
                            input int sc, input int fe);
    exp_t e;
    e.name = name;
    e.ctl  = ctl;
    e.sc   = CW'(sc);
    e.fe   = CW'(fe);
    exp_q.push_back(e);
  endtask

  initial begin
    idle();
    tick(); expect_out("reset", NONE, 0, 0);
    tick(); bus.mem_busy = 1'b1; bus.branch_taken = 1'b1;
            expect_out("reset_gated", NONE, 0, 0);
    tick(); rst_n = 1'b1; idle(); expect_out("post_reset", NONE, 0, 0);

    // load-use on rs, then index 0 and uses_rt gating
    tick(); idle(); dec(5, 4, 1, 1, 0, 0); exe(1, 1, 5); expect_out("lu_rs", LU, 0, 0);
    tick(); idle(); dec(5, 4, 1, 1, 0, 0); expect_out("lu_clear", NONE, 1, 0);
    tick(); idle(); dec(0, 0, 1, 1, 0, 0); exe(1, 1, 0); expect_out("lu_r0", NONE, 1, 0);
    tick(); idle(); dec(3, 7, 1, 0, 0, 0); exe(1, 1, 7); expect_out("lu_no_uses_rt", NONE, 1, 0);
    tick(); idle(); dec(3, 7, 1, 1, 0, 0); exe(1, 1, 7); expect_out("lu_rt", LU, 1, 0);
    tick(); idle(); dec(3, 7, 1, 1, 0, 0); exe(1, 0, 7); expect_out("lu_no_rw", NONE, 2, 0);

    // priority: mem_busy over branch over load-use
    tick(); idle(); dec(5, 4, 1, 0, 0, 0); exe(1, 1, 5);
            bus.branch_taken = 1'b1; bus.mem_busy = 1'b1;
            expect_out("all_three", MEM, 2, 0);
    tick(); idle(); dec(5, 4, 1, 0, 0, 0); exe(1, 1, 5);
            bus.branch_taken = 1'b1; expect_out("br_over_lu", BR, 3, 0);
    tick(); idle(); expect_out("after_br", NONE, 3, 1);

    // div squashed by branch must not launch
    tick(); idle(); dec(0, 0, 0, 0, 1, 0); bus.branch_taken = 1'b1;
            expect_out("div_br", BR, 3, 1);
    tick(); idle(); expect_out("div_br_idle", NONE, 3, 2);

    // div launch, 4 busy cycles with mflo / second div held off
    tick(); idle(); dec(0, 0, 0, 0, 1, 0); expect_out("div_start", DS, 3, 2);
    tick(); idle(); dec(0, 0, 0, 0, 0, 1); expect_out("hilo_b1", LU | DB, 3, 2);
    tick(); idle(); dec(0, 0, 0, 0, 0, 1); expect_out("hilo_b2", LU | DB, 4, 2);
    tick(); idle(); dec(0, 0, 0, 0, 0, 1); bus.mem_busy = 1'b1;
            expect_out("mem_b3", MEM | DB, 5, 2);
    tick(); idle(); dec(0, 0, 0, 0, 1, 0); expect_out("div2_b4", LU | DB, 6, 2);
    tick(); idle(); dec(0, 0, 0, 0, 1, 0); expect_out("div2_start", DS, 7, 2);
    tick(); idle(); dec(0, 0, 0, 0, 0, 1); expect_out("div2_hilo", LU | DB, 7, 2);
    tick(); idle(); expect_out("div2_b2", DB, 8, 2);

    // asynchronous reset mid-division
    tick(); idle(); rst_n = 1'b0; expect_out("rst_mid_div", NONE, 0, 0);
    tick(); rst_n = 1'b1; idle(); expect_out("rst_release", NONE, 0, 0);

    // 2^CW+3 stall cycles saturate the counter
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      tick(); idle(); bus.mem_busy = 1'b1;
      expect_out("sat_stall", MEM, (i > 15) ? 15 : i, 0);
    end
    tick(); idle(); expect_out("sat_hold", NONE, 15, 0);
    tick(); idle(); bus.branch_taken = 1'b1; expect_out("final_br", BR, 15, 0);
    tick(); idle(); expect_out("final_idle", NONE, 15, 1);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
